// File: rtl/arith_arb_pkg.sv
// Shared types and helpers for the arith_share_arb round-robin sequencer.
package arith_arb_pkg;

    localparam int DEF_W    = 32;
    localparam int DEF_NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic int unsigned next_rr(input int unsigned id, input int unsigned nreq);
        return (id + 1) % nreq;
    endfunction

endpackage

// File: rtl/arith_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or above ptr, with wrap.
module arith_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   oh;
    logic [2*NREQ-1:0] dbl;
    logic [IDW-1:0]    ofs;
    logic [IDW:0]      sum;
    logic              found;

    always_comb begin
        // rotate so ptr sits at bit 0, pick lowest, then rotate the grant back
        rot   = NREQ'({req, req} >> ptr);
        oh    = '0;
        ofs   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                oh[i] = 1'b1;
                ofs   = IDW'(i);
                found = 1'b1;
            end
        end
        dbl    = {{NREQ{1'b0}}, oh} << ptr;
        gnt    = dbl[NREQ-1:0] | dbl[2*NREQ-1:NREQ];
        sum    = {1'b0, ptr} + {1'b0, ofs};
        gnt_id = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
    end

endmodule

// File: rtl/yArith.sv
// 32-bit add/subtract datapath: ctrl=1 computes a + ~b + 1, ctrl=0 computes a + b.
module yArith (
    output logic [31:0] z,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ctrl
);

    assign {cout, z} = {1'b0, a} + {1'b0, b ^ {32{ctrl}}} + {32'd0, ctrl};

endmodule

// File: rtl/arith_share_arb.sv
// Round-robin sequencer time-sharing one yArith among NREQ requesters.
// Optional ARITH_ARB_OVF_EN adds the registered signed-overflow output rsp_ovf.
module arith_share_arb
    import arith_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_z,
    output logic              rsp_cout
`ifdef ARITH_ARB_OVF_EN
    ,
    output logic              rsp_ovf
`endif
);

    arb_state_t      state, state_nxt;
    logic [IDW-1:0]  rr_ptr, op_id, gnt_id;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    op_a, op_b, sel_a, sel_b, zw;
    logic            op_sub, sel_sub;
    logic [31:0]     ya, yb, yz;
    logic            ycout;

    arith_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_sub = req_sub[i];
            end
        end
    end

    assign ya = 32'(op_a);
    assign yb = 32'(op_b);
    assign zw = W'(yz);

    yArith u_arith (
        .z    (yz),
        .cout (ycout),
        .a    (ya),
        .b    (yb),
        .ctrl (op_sub)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                req_ready = gnt;
                if (|req_valid) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (|req_valid) begin
                    op_a   <= sel_a;
                    op_b   <= sel_b;
                    op_sub <= sel_sub;
                    op_id  <= gnt_id;
                end
                EXEC: begin
                    rsp_z     <= zw;
                    rsp_cout  <= ycout;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    rr_ptr    <= IDW'(next_rr(32'(op_id), NREQ));
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef ARITH_ARB_OVF_EN
    logic ovf;
    assign ovf = (op_sub ? (op_a[W-1] != op_b[W-1]) : (op_a[W-1] == op_b[W-1]))
                 && (zw[W-1] != op_a[W-1]);

    always_ff @(posedge clk) begin
        if (reset)              rsp_ovf <= 1'b0;
        else if (state == EXEC) rsp_ovf <= ovf;
    end
`endif

endmodule

// File: tb/tb_arith_share_arb.sv
// Self-checking bench for arith_share_arb: directed scenarios plus randomized traffic
// against a transaction-level model (round-robin pick, arithmetic, latency, fairness).
module tb_arith_share_arb;

    localparam int NREQ = 3;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_sub, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready, rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_z;
`ifdef ARITH_ARB_OVF_EN
    logic              rsp_ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_count   = 0;

    arith_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_cout  (rsp_cout)
`ifdef ARITH_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         id;
        logic [W-1:0] z;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t pe;
    bit   pend        = 1'b0;
    int   last_served = NREQ - 1;
    int   wait_cnt[NREQ];

    // the requester served last gets lowest priority: search starts just after it
    function automatic logic [NREQ-1:0] model_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (v[j]) return NREQ'(1) << j;
        end
        return '0;
    endfunction

    function automatic exp_t model_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub);
        exp_t       e;
        logic [W:0] s;
        e.id = id;
        if (sub) begin
            e.z   = a - b;
            s     = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            e.ovf = (a[W-1] != b[W-1]) && (e.z[W-1] != a[W-1]);
        end else begin
            e.z   = a + b;
            s     = {1'b0, a} + {1'b0, b};
            e.ovf = (a[W-1] == b[W-1]) && (e.z[W-1] != a[W-1]);
        end
        e.cout = s[W];
        e.due  = 0;
        return e;
    endfunction

    always @(negedge clk) begin : compare
        logic [NREQ-1:0] expr, dhs;
        int gid;
        cyc++;
        if (reset) begin
            pend        = 1'b0;
            last_served = NREQ - 1;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        end else begin
            expr = pend ? '0 : model_pick(req_valid, last_served);
            chk("req_ready", req_ready, expr);
            if (pend && cyc >= pe.due) begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_id", rsp_id, pe.id);
                chk("rsp_z", rsp_z, pe.z);
                chk("rsp_cout", rsp_cout, pe.cout);
`ifdef ARITH_ARB_OVF_EN
                chk("rsp_ovf", rsp_ovf, pe.ovf);
`endif
                if (rsp_ready) pend = 1'b0;
            end else begin
                chk("rsp_valid_quiet", rsp_valid, 0);
            end
            if (expr != '0) begin
                gid = 0;
                for (int i = 0; i < NREQ; i++) if (expr[i]) gid = i;
                pe = model_op(gid, req_a[gid*W +: W], req_b[gid*W +: W], req_sub[gid]);
                pe.due      = cyc + 2;
                pend        = 1'b1;
                last_served = gid;
                acc_count++;
            end
            // fairness measured on the DUT's own grants
            dhs = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || dhs[i]) begin
                    wait_cnt[i] = 0;
                end else if (dhs != '0) begin
                    wait_cnt[i]++;
                    chk("fair_wait_ok", wait_cnt[i] < NREQ, 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic neg();
        @(negedge clk);
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i]      = s;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return '1;
            3:       return '0;
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        logic [NREQ-1:0] hs;
        int gseq[5];
        int gn;
        int start;

        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;
        pos();
        pos();
        reset = 1'b0;
        neg();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_z", rsp_z, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_cout", rsp_cout, 0);
`ifdef ARITH_ARB_OVF_EN
        chk("reset_rsp_ovf", rsp_ovf, 0);
`endif

        // reset while the accepted op is executing
        pos();
        set_op(0, 32'd5, 32'd3, 1'b0);
        req_valid = 3'b001;
        neg();
        chk("t1_grant", req_ready, 3'b001);
        pos();
        req_valid = '0;
        reset     = 1'b1;
        neg();
        pos();
        reset = 1'b0;
        neg();
        chk("t1_discarded", rsp_valid, 0);

        // rr_ptr back at 0, single-cycle ready pulse, two-cycle latency
        pos();
        set_op(0, 32'd7, 32'hFFFF_FFFE, 1'b0);
        set_op(1, 32'd10, 32'd3, 1'b1);
        req_valid = 3'b011;
        rsp_ready = 1'b1;
        neg();
        chk("t2_grant", req_ready, 3'b001);
        pos();
        req_valid[0] = 1'b0;
        neg();
        chk("t2_pulse", req_ready, 3'b000);
        pos();
        neg();
        chk("t2_valid", rsp_valid, 1);
        chk("t2_z", rsp_z, 32'd5);
        chk("t2_id", rsp_id, 0);
        chk("t2_cout", rsp_cout, 1);
        pos();
        neg();
        chk("t2_next_grant", req_ready, 3'b010);
        pos();
        req_valid[1] = 1'b0;
        neg();
        pos();
        neg();
        chk("t2_sub_z", rsp_z, 32'd7);
        chk("t2_sub_id", rsp_id, 1);
        pos();

        // signed wrap on subtract
        set_op(1, 32'h8000_0000, 32'd1, 1'b1);
        req_valid = 3'b010;
        neg();
        chk("t4_grant", req_ready, 3'b010);
        pos();
        req_valid = '0;
        neg();
        pos();
        neg();
        chk("t4_z", rsp_z, 32'h7FFF_FFFF);
        chk("t4_id", rsp_id, 1);
`ifdef ARITH_ARB_OVF_EN
        chk("t4_ovf", rsp_ovf, 1);
`endif
        pos();

        // backpressure hold, then service passes to the other requester
        rsp_ready = 1'b0;
        set_op(0, 32'd100, 32'd1, 1'b0);
        set_op(1, 32'd50, 32'd60, 1'b1);
        req_valid = 3'b011;
        neg();
        chk("t5_grant", req_ready, 3'b001);
        pos();
        set_op(0, 32'd200, 32'd5, 1'b0);
        neg();
        pos();
        for (int n = 0; n < 5; n++) begin
            neg();
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_z", rsp_z, 32'd101);
            chk("t5_hold_id", rsp_id, 0);
            chk("t5_hold_ready", req_ready, 3'b000);
            pos();
        end
        rsp_ready = 1'b1;
        neg();
        pos();
        neg();
        chk("t5_other", req_ready, 3'b010);

        // continuous contention alternates grants
        gn = 0;
        for (int n = 0; n < 60 && gn < 5; n++) begin
            hs = req_valid & req_ready;
            if (hs != '0) begin
                gseq[gn] = hs[1] ? 1 : (hs[0] ? 0 : 2);
                gn++;
            end
            pos();
            for (int i = 0; i < 2; i++)
                if (hs[i]) set_op(i, $urandom, $urandom, (i == 1));
            neg();
        end
        chk("t3_grant_count", gn, 5);
        for (int k = 0; k < 5; k++) chk("t3_seq", gseq[k], (k % 2 == 0) ? 1 : 0);
        pos();
        req_valid = '0;

        // randomized traffic
        start = acc_count;
        for (int n = 0; n < 15000 && (acc_count - start) < 1000; n++) begin
            neg();
            hs = req_valid & req_ready;
            pos();
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        set_op(i, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        chk("random_ops_done", (acc_count - start) >= 1000, 1);

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) begin
            neg();
            pos();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
